// File: rtl/tt_readout_tx.sv
// Serial readout transmitter: buffers 8-bit samples in a small FIFO and shifts
// each one out as a 9-bit frame (MSB first, then even parity) on data/clock/frame pins.
module tt_readout_tx #(
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               sample_in,
  input  logic                     capture,
  input  logic                     clr_ovf,
  output logic                     ser_data,
  output logic                     ser_clk,
  output logic                     ser_frame,
  output logic                     busy,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [PW:0]   DEPTH_L  = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  logic fifo_empty, div_end, pop, push, drop;

  assign fifo_empty = (count == '0);
  assign div_end    = (div_cnt == DIV_LAST);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = SHIFT;
          pop       = 1'b1;
        end
      end
      SHIFT: begin
        if (div_end && bit_cnt == 4'd8) state_nxt = GAP;
      end
      GAP: begin
        if (div_end) begin
          if (!fifo_empty) begin
            state_nxt = SHIFT;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!ena) begin
      state_nxt = state;
      pop       = 1'b0;
    end
    // A pop frees a slot this cycle, so a push into a full FIFO still lands.
    push = ena && capture && (count != DEPTH_L || pop);
    drop = ena && capture && (count == DEPTH_L) && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: sample storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (ena) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (pop) begin
        shreg   <= {mem[rd_ptr], ^mem[rd_ptr]};
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (state != IDLE) begin
        if (div_end) begin
          div_cnt <= '0;
          if (state == SHIFT) begin
            bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
            shreg   <= {shreg[7:0], 1'b0};
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  assign ser_frame = (state == SHIFT);
  assign ser_data  = (state == SHIFT) && shreg[8];
  assign ser_clk   = (state == SHIFT) && (div_cnt >= DIV_HALF);
  assign busy      = (state != IDLE);
  assign full      = (count == DEPTH_L);
  assign level     = count;

endmodule

// File: tb/tb_tt_readout_tx.sv
// Directed bench for tt_readout_tx: a negedge monitor decodes serial frames and
// a scoreboard queue of expected frames is compared against them.
module tb_tt_readout_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, capture = 1'b0, clr_ovf = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       ser_data, ser_clk, ser_frame, busy, full, overflow;
  logic [2:0] level;

  always #5 clk = ~clk;

  tt_readout_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
    .capture(capture), .clr_ovf(clr_ovf), .ser_data(ser_data),
    .ser_clk(ser_clk), .ser_frame(ser_frame), .busy(busy), .full(full),
    .overflow(overflow), .level(level)
  );

  typedef struct { logic [7:0] data; logic par; int nrise; int hi_len; int gap; int glitch; } rx_frame_t;
  typedef struct { logic [7:0] data; int hi_len; int gap; } exp_frame_t;

  rx_frame_t  rx_q[$];
  exp_frame_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int level_peak = 0;

  logic [7:0] seq_a [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
  logic [7:0] seq_b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] seq_c [6] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};

  // Frame decoder state; a frame cut short by reset is discarded.
  logic [8:0] m_sh = '0;
  int m_nrise = 0, m_hi = 0, m_lo = 0, m_gap = 0, m_glitch = 0;
  logic m_pclk = 1'b0, m_pdata = 1'b0, m_pframe = 1'b0;
  rx_frame_t m_rec;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pframe = 1'b0;
      m_pclk   = 1'b0;
      m_pdata  = 1'b0;
      m_lo     = 0;
    end else begin
      if (int'(level) > level_peak) level_peak = int'(level);
      if (ser_frame) begin
        if (!m_pframe) begin
          m_sh = '0; m_nrise = 0; m_hi = 0; m_glitch = 0; m_gap = m_lo;
        end
        m_hi++;
        if (ser_clk && !m_pclk) begin
          m_sh = {m_sh[7:0], ser_data};
          m_nrise++;
        end
        if (m_pframe && ser_clk && ser_data !== m_pdata) m_glitch++;
        m_lo = 0;
      end else begin
        if (m_pframe) begin
          m_rec.data   = m_sh[8:1];
          m_rec.par    = m_sh[0];
          m_rec.nrise  = m_nrise;
          m_rec.hi_len = m_hi;
          m_rec.gap    = m_gap;
          m_rec.glitch = m_glitch;
          rx_q.push_back(m_rec);
        end
        m_lo++;
      end
      m_pframe = ser_frame;
      m_pclk   = ser_clk;
      m_pdata  = ser_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int hi, input int gap);
    exp_frame_t e;
    e.data = d; e.hi_len = hi; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_frame(input string tag);
    exp_frame_t e;
    rx_frame_t  r;
    int t = 0;
    while (rx_q.size() == 0 && t < 3000) begin
      tick();
      t++;
    end
    check({tag, "_present"}, rx_q.size() != 0, 1);
    if (rx_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      check({tag, "_data"},   r.data,   e.data);
      check({tag, "_parity"}, r.par,    ^e.data);
      check({tag, "_nrise"},  r.nrise,  9);
      check({tag, "_hilen"},  r.hi_len, e.hi_len);
      check({tag, "_glitch"}, r.glitch, 0);
      if (e.gap >= 0) check({tag, "_gap"}, r.gap, e.gap);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || level != 0) && t < 3000) begin
      tick();
      t++;
    end
    check("idle_reached", {busy, level}, 0);
  endtask

  initial begin
    int n;
    logic [8:0] snap;

    // Reset state
    tick();
    check("rst_outputs", {ser_data, ser_clk, ser_frame, busy, full, overflow, level}, 0);
    #2 rst_n = 1'b1;
    tick();

    // Single frame 0xA5: latency and frame/busy duration
    sample_in = 8'hA5; capture = 1'b1; push_exp(8'hA5, 36, -1);
    tick(); capture = 1'b0;
    check("lat_level_e0", level, 1);
    check("lat_busy_e0", busy, 0);
    tick();
    check("lat_level_e1", level, 0);
    check("lat_out_e1", {busy, ser_frame, ser_data}, 3'b111);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("busy_len", n, 40);
    expect_frame("a5");

    // Four back-to-back samples
    level_peak = 0;
    for (int i = 0; i < 4; i++) begin
      sample_in = seq_a[i]; capture = 1'b1;
      push_exp(seq_a[i], 36, (i == 0) ? -1 : 4);
      tick();
    end
    capture = 1'b0;
    for (int i = 0; i < 4; i++) expect_frame("seq4");
    wait_idle();
    check("level_peak", level_peak, 3);

    // Six captures: last one dropped, overflow sticky until cleared
    for (int i = 0; i < 6; i++) begin
      sample_in = seq_b[i]; capture = 1'b1;
      if (i < 5) push_exp(seq_b[i], 36, (i == 0) ? -1 : 4);
      tick();
    end
    capture = 1'b0;
    check("ovf_set", {overflow, full, level}, {1'b1, 1'b1, 3'd4});
    for (int i = 0; i < 5; i++) expect_frame("ovf");
    wait_idle();
    check("ovf_sticky", overflow, 1);
    check("no_dropped_frame", rx_q.size(), 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO with a push on the exact pop cycle
    for (int i = 0; i < 5; i++) begin
      sample_in = seq_c[i]; capture = 1'b1;
      push_exp(seq_c[i], 36, (i == 0) ? -1 : 4);
      tick();
    end
    capture = 1'b0;
    repeat (36) tick();
    check("pre_pop_full", {full, level}, {1'b1, 3'd4});
    sample_in = seq_c[5]; capture = 1'b1; push_exp(seq_c[5], 36, 4);
    tick(); capture = 1'b0;
    check("pop_push_level", {full, overflow, level}, {1'b1, 1'b0, 3'd4});
    for (int i = 0; i < 6; i++) expect_frame("poppush");
    wait_idle();

    // ena low for 10 cycles in the middle of bit 3; captures ignored meanwhile
    sample_in = 8'h3C; capture = 1'b1; push_exp(8'h3C, 46, -1);
    tick(); capture = 1'b0;
    repeat (14) tick();
    snap = {ser_data, ser_clk, ser_frame, busy, full, overflow, level};
    ena = 1'b0; sample_in = 8'h99; capture = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ena_freeze", {ser_data, ser_clk, ser_frame, busy, full, overflow, level}, snap);
    end
    capture = 1'b0; ena = 1'b1;
    expect_frame("ena");
    wait_idle();
    check("ena_capture_ignored", rx_q.size(), 0);

    // Asynchronous reset mid-frame with a sample still queued
    sample_in = 8'h5A; capture = 1'b1; tick();
    sample_in = 8'h5B; tick(); capture = 1'b0;
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1 check("async_rst", {ser_data, ser_clk, ser_frame, busy, full, overflow, level}, 0);
    tick();
    #2 rst_n = 1'b1;
    repeat (50) tick();
    check("post_rst_idle", {busy, ser_frame, level}, 0);
    check("post_rst_no_frame", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
